// File: rtl/cond_entradas.sv
// Input conditioning for the functional encoder: synchronizes and debounces raw
// switches/buttons and produces A/B/C, the INTERF toggle and the atv_PRIO window.
module cond_entradas #(
  parameter int DEB_CICLOS = 250000,
  parameter int ATV_CICLOS = 50000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SW_A,
  input  logic SW_B,
  input  logic SW_C,
  input  logic BTN_INTERF,
  input  logic BTN_PRIO,
  output logic A,
  output logic B,
  output logic C,
  output logic INTERF,
  output logic atv_PRIO
);

  localparam int CW = $clog2(DEB_CICLOS);
  localparam int TW = $clog2(ATV_CICLOS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CICLOS - 1);
  localparam logic [TW-1:0] TMR_MAX = TW'(ATV_CICLOS - 1);

  typedef enum logic {OCIOSO, ATIVO} estado_t;

  // Channel order: 4=SW_A, 3=SW_B, 2=SW_C, 1=BTN_INTERF, 0=BTN_PRIO
  logic [4:0]    raw;
  logic [4:0]    s1;
  logic [4:0]    s2;
  logic [4:0]    deb;
  logic [CW-1:0] cnt [5];
  logic [1:0]    deb_prev;
  logic          interf_rise;
  logic          prio_rise;
  estado_t       estado;
  logic [TW-1:0] tmr;

  assign raw = {SW_A, SW_B, SW_C, BTN_INTERF, BTN_PRIO};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Any return of s2 to the accepted level throws away the partial count
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      deb <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign interf_rise = deb[1] & ~deb_prev[1];
  assign prio_rise   = deb[0] & ~deb_prev[0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      deb_prev <= '0;
      INTERF   <= 1'b0;
    end else begin
      deb_prev <= deb[1:0];
      if (interf_rise) INTERF <= ~INTERF;
    end
  end

  // A retrigger always wins over expiry, so back-to-back presses keep the window open
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      estado <= OCIOSO;
      tmr    <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (prio_rise) begin
            estado <= ATIVO;
            tmr    <= TMR_MAX;
          end
        end
        ATIVO: begin
          if (prio_rise) begin
            tmr <= TMR_MAX;
          end else if (tmr == '0) begin
            estado <= OCIOSO;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign atv_PRIO = (estado == ATIVO);
  assign A = deb[4];
  assign B = deb[3];
  assign C = deb[2];

endmodule

// File: doc/cond_entradas.md
# cond_entradas

Input conditioning stage that sits directly upstream of the functional encoder. It takes raw push-button/switch levels from the board, synchronizes and debounces them, and produces the encoder's control inputs. The outputs are the clean data levels A, B, C, the interface select INTERF (toggle LEDs/matrix), and the priority enable atv_PRIO (a retriggerable timed window). All outputs are registered and glitch-free, so the encoder's combinational outputs stay stable.

## Interface

Parameters:
- DEB_CICLOS, default 250000: consecutive stable cycles required to accept a new input level (5 ms at 50 MHz); legal range ≥ 2.
- ATV_CICLOS, default 50000000: length of the atv_PRIO window in clock cycles (1 s at 50 MHz); legal range ≥ 2.

Ports:
- CLK, input, 1 bit: single system clock, rising-edge.
- RST_N, input, 1 bit: reset, asynchronous and active-low.
- SW_A, SW_B, SW_C, input, 1 bit each: raw asynchronous data switches.
- BTN_INTERF, input, 1 bit: raw button; each accepted press toggles INTERF.
- BTN_PRIO, input, 1 bit: raw button; each accepted press (re)starts the priority window.
- A, B, C, output, 1 bit each: debounced levels of SW_A, SW_B, SW_C.
- INTERF, output, 1 bit: interface select; 0 selects LEDs, 1 selects matrix.
- atv_PRIO, output, 1 bit: high while the priority window is open.

## Operation

**Front end (per raw input, 5 identical channels)**
- Each raw input passes through a 2-FF synchronizer (s1, s2), then into a debouncer that holds a debounced level `deb` and a counter `cnt`.
- The counter is $clog2(DEB_CICLOS) bits wide.
- If s2 == deb: cnt <= 0.
- If s2 != deb and cnt == DEB_CICLOS-1: deb <= s2 and cnt <= 0.
- Otherwise: cnt <= cnt+1.
- A bounce (s2 returning to deb) before the count completes discards the progress. The level is accepted only after DEB_CICLOS consecutive mismatching cycles.

**Data outputs**
- A, B, C are the `deb` registers of SW_A, SW_B, SW_C, driven directly.

**INTERF toggle**
- A registered edge detector flags a rising edge when deb_INTERF is 1 now and was 0 last cycle.
- On that edge, INTERF <= ~INTERF. Falling edges and held presses have no effect.

**Priority FSM**
- States: OCIOSO (atv_PRIO=0) and ATIVO (atv_PRIO=1). A down-counter `tmr` is $clog2(ATV_CICLOS) bits wide.
- OCIOSO, on a rising edge of deb_PRIO: go to ATIVO, tmr <= ATV_CICLOS-1.
- ATIVO, on a rising edge of deb_PRIO: tmr <= ATV_CICLOS-1 (retrigger).
- ATIVO, no edge, tmr == 0: go to OCIOSO.
- ATIVO, no edge, tmr != 0: tmr <= tmr-1.
- If a retrigger coincides with tmr == 0, the retrigger wins: the FSM stays in ATIVO and reloads.
- atv_PRIO is decoded from the state register only, with no combinational path from inputs.

**Reset (RST_N=0, asynchronous)**
- Synchronizers, deb, cnt, edge-detector history, INTERF, tmr and atv_PRIO all go to 0; the FSM goes to OCIOSO.
- Asserting RST_N mid-window or mid-debounce aborts it immediately.
- If a raw input is high when RST_N deasserts, it is accepted after the normal latency. For BTN_INTERF and BTN_PRIO this counts as a rising edge.

## Timing

- **Debounce latency:** let edge n be the first rising edge that samples a new stable raw level. deb changes after edge n+1+DEB_CICLOS.
- **A/B/C latency:** the same as the debounce latency, DEB_CICLOS+2 edges.
- **INTERF latency:** one edge after deb_INTERF rises, i.e. after edge n+2+DEB_CICLOS.
- **atv_PRIO rise:** after edge n+2+DEB_CICLOS.
- **atv_PRIO width:** high for exactly ATV_CICLOS cycles after the last accepted rising edge of BTN_PRIO.
- **Channel independence:** channels do not interact. Simultaneous presses on BTN_INTERF and BTN_PRIO are both honoured in the same cycle.
- **Reset values:** every output is 0 in reset.

## Test plan

Bench parameters: DEB_CICLOS=4, ATV_CICLOS=10.

1. **Clean switch:** SW_A 0→1 held stable, first sampled at edge n -> A rises after edge n+5. B, C, INTERF and atv_PRIO remain 0.
2. **Bounce rejection:** SW_B toggles 1,0,1,0 with 3-cycle pulses, then holds 1 -> B stays 0 during the bounce and rises only after 4 consecutive synchronized-high cycles.
3. **INTERF toggle:** three clean BTN_INTERF presses of 8 cycles each, with 8-cycle gaps -> INTERF goes 0→1→0→1, one toggle per press, each one cycle after deb_INTERF rises. Holding the button 50 cycles does not re-toggle.
4. **Priority window:** one BTN_PRIO press -> atv_PRIO high for exactly 10 cycles, then 0.
5. **Priority retrigger:** a second accepted press lands when tmr==3 -> the window extends to 10 cycles from the second edge. A press landing exactly at tmr==0 keeps atv_PRIO continuously high.
6. **Reset cases:**
   - RST_N pulled low while atv_PRIO=1 and INTERF=1 -> both go to 0 immediately, without waiting for CLK.
   - BTN_PRIO held high through reset release -> atv_PRIO rises DEB_CICLOS+3 edges later.
